// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add MULT, restoring DIV, MTHI/MTLO writes.
// Latency: MULT/DIV result and done appear WIDTH+1 cycles after the accepting edge; MTHI/MTLO write at the accepting edge.
// Backpressure: busy holds the core; start is ignored for every op while busy, and accepted again in the done cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    // MULT: multiplicand magnitude; DIV: divisor magnitude
    logic [WIDTH-1:0]   opnd;
    // MULT: {partial product high, remaining multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] prod;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_orig;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && start && (op == OP_MULT || op == OP_DIV);
    assign last_step = (cnt == CNT_W'(WIDTH-1));

    // Magnitudes: -0x80..0 wraps to itself, which read unsigned is exactly 2^(WIDTH-1)
    assign a_mag = (Sign && A[WIDTH-1]) ? -A : A;
    assign b_mag = (Sign && B[WIDTH-1]) ? -B : B;

    // One shift-add step: add multiplicand to the high half when the multiplier LSB is set
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // One restoring step: bring in next dividend bit, trial-subtract the divisor
    assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_diff[WIDTH];

    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fixed WIDTH iterations then one sign-fix cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (op == OP_DIV) ? S_DIV : S_MUL;
                end
            end
            S_MUL:   if (last_step) state_nxt = S_FIX;
            S_DIV:   if (last_step) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and HI/LO/flag update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            opnd     <= '0;
            prod     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            a_orig   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi <= A;
                        end else if (op == OP_MTLO) begin
                            lo <= A;
                        end else begin
                            is_div   <= (op == OP_DIV);
                            opnd     <= (op == OP_DIV) ? b_mag : a_mag;
                            prod     <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? a_mag : b_mag)};
                            neg_res  <= Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_rem  <= Sign && A[WIDTH-1];
                            b_zero   <= (B == '0);
                            a_orig   <= A;
                            div_zero <= 1'b0;
                            cnt      <= '0;
                        end
                    end
                end
                S_MUL: begin
                    prod <= {mul_sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    prod <= div_ok ? {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1}
                                   : {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (b_zero) begin
                        lo       <= '1;
                        hi       <= a_orig;
                        div_zero <= 1'b1;
                    end else begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboarded directed bench for mul_div_unit.
// Latency: expected done cycle is accept cycle + 33.
// Backpressure: exercises start-while-busy and back-to-back issue in the done cycle.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        Sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .Sign     (Sign),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_done: got done=1 with empty scoreboard at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_hi", 64'(hi), 64'(e.hi));
                chk("res_lo", 64'(lo), 64'(e.lo));
                chk("res_div_zero", 64'(div_zero), 64'(e.dz));
                chk("res_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        exp_t e;
        start = 1'b1;
        op    = o;
        Sign  = s;
        A     = a;
        B     = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A     = 32'h5A5A_A5A5;
        B     = 32'hA5A5_5A5A;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dz  = edz;
            e.cyc = cyc + 33;
            q.push_back(e);
            chk("busy_after_accept", 64'(busy), 64'd1);
            chk("div_zero_clear_at_accept", 64'(div_zero), 64'd0);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done=1", n);
        end
    endtask

    initial begin
        int   ndone;
        int   n;
        bit   stable;

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        Sign  = 1'b0;
        A     = '0;
        B     = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // MTLO / MTHI in IDLE
        issue(2'b11, 1'b0, 32'h1234_5678, 32'h0, 1'b0, '0, '0, 1'b0);
        chk("mtlo_lo", 64'(lo), 64'h1234_5678);
        chk("mtlo_done", 64'(done), 64'd0);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_hi_untouched", 64'(hi), 64'd0);
        issue(2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, '0, '0, 1'b0);
        chk("mthi_hi", 64'(hi), 64'hCAFE_F00D);
        chk("mthi_done", 64'(done), 64'd0);

        // Multiplies
        issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        chk("hi_held_during_busy", 64'(hi), 64'hCAFE_F00D);
        wait_done();
        issue(2'b00, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done();
        issue(2'b00, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done();

        // Divides
        issue(2'b01, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        issue(2'b01, 1'b0, 32'h0000_0007, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'h0000_0003, 1'b0);
        wait_done();
        issue(2'b01, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        // Back-to-back in the done cycle; div_zero must clear at this accept
        issue(2'b00, 1'b0, 32'h0000_0002, 32'h0000_0003, 1'b1, 32'h0000_0000, 32'h0000_0006, 1'b0);
        wait_done();
        issue(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done();
        issue(2'b01, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        wait_done();

        // MTHI while busy must be ignored; HI/LO stay put for the whole busy period
        issue(2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0);
        issue(2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, '0, '0, 1'b0);
        chk("mthi_busy_ignored", 64'(hi), 64'h0000_0001);
        stable = 1'b1;
        n = 0;
        while (!done && n < 60) begin
            if (busy && (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFD)) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("hilo_stable_busy", 64'(stable), 64'd1);
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL done_timeout_busy_mthi: got no done within %0d cycles, required done=1", n);
        end

        // Reset in the middle of a DIV
        issue(2'b01, 1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        if (q.size() > 0) void'(q.pop_back());
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_reset", 64'(ndone), 64'd0);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU.
- Takes the same A/B operands and Sign control that feed the ALU.
- Produces the HI/LO result pair for MULT/DIV and accepts MTHI/MTLO writes.
- Holds the core through a busy/done handshake while a 32-step shift-add or restoring-division sequence runs.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- op  input  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- Sign  input  1  1 = signed operands, 0 = unsigned (same meaning as for the ALU).
- A  input  WIDTH  multiplicand, dividend, or MTHI/MTLO source.
- B  input  WIDTH  multiplier or divisor.
- busy  output  1  high while a MULT/DIV is in progress.
- done  output  1  one-cycle pulse when HI/LO hold a new MULT/DIV result.
- div_zero  output  1  sticky flag: the last DIV had B=0; cleared by the next accepted MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE
  - busy=0, done=0, div_zero=0
  - hi=0, lo=0
  - counter=0
- Reset asserted mid-operation aborts the operation; no partial result is written.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1, op=10: hi<=A at this edge; stay IDLE; no busy, no done.
  - start=1, op=11: lo<=A at this edge; stay IDLE; no busy, no done.
  - start=1, op=00 or 01:
    - latch |A| and |B| when Sign=1, otherwise raw A and B.
    - latch the result sign bits.
    - clear div_zero and the counter.
    - go to MUL (op=00) or DIV (op=01); busy=1 from this edge.
- MUL: one shift-add step per cycle into a 2*WIDTH partial product; after WIDTH steps (counter=WIDTH-1), go to FIX.
- DIV: one restoring-subtract step per cycle (remainder shift, trial subtract, quotient bit); after WIDTH steps, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - MULT: product negated when A[31]^B[31] and Sign=1; hi<=product[63:32], lo<=product[31:0].
  - DIV: quotient truncates toward zero (negated when signs differ, Sign=1); remainder takes the sign of the dividend; lo<=quotient, hi<=remainder.
  - Transition to IDLE; busy<=0; done<=1 for exactly one cycle.
- Latency: start accepted at edge N; hi/lo/done visible after edge N+WIDTH+1 (33 cycles for WIDTH=32). Latency is fixed and independent of operand values.
- hi/lo are unchanged for the whole busy period; the core reads stale HI/LO only if it ignores busy.
- start while busy=1 is ignored for every op, including MTHI/MTLO; operand changes during busy have no effect.
- Divide by zero (B=0):
  - same latency as a normal DIV
  - lo=all ones, hi=A (original, uncorrected dividend)
  - div_zero=1 at the same edge as done
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
- Magnitude of 0x80000000 is handled as the unsigned value 2^31; the internal datapath is WIDTH bits unsigned plus a separate sign bit, so no overflow occurs.
- start in the same cycle as done (state IDLE after FIX): accepted normally, giving back-to-back operations with no bubble.

Test Plan:
- Sign=0, MULT, A=B=0xFFFFFFFF → busy for 33 cycles; done one cycle; hi=0xFFFFFFFE, lo=0x00000001.
- Sign=1, MULT, A=0xFFFFFFFD (−3), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Sign=1, MULT, A=0x80000000, B=0xFFFFFFFF → hi=0x00000000, lo=0x80000000.
- Sign=1, DIV, A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with Sign=0, A=7, B=2 → lo=3, hi=1.
- DIV, A=5, B=0 → lo=0xFFFFFFFF, hi=5, div_zero=1; next MULT 2×3 → div_zero cleared at accept, lo=6, hi=0.
- Handshake and reset cases:
  - MTLO A=0x12345678 in IDLE → lo=0x12345678 next edge, done stays 0.
  - MTHI issued while busy → ignored.
  - reset pulled low at cycle 10 of a DIV → busy=0, hi=lo=0 immediately; no done pulse afterward.
